// File: rtl/fmem_pkg.sv
// fmem_pkg: shared types, timing field widths and mode decode for the frame-memory read stream
package fmem_pkg;
  typedef enum logic [1:0] {MODE_NORMAL, MODE_MIRROR, MODE_FILL} mode_e;
  typedef enum logic [1:0] {ST_UNLOCKED, ST_VBLANK, ST_VACTIVE, ST_VDONE} state_e;
  localparam int PORCH_W = 10;
  localparam int PULSE_W = 4;
  localparam int RES_W   = 11;
  localparam int HCNT_W  = 12;
  localparam int VCNT_W  = 11;
  // mirror needs whole words per line; anything else falls back to normal
  function automatic mode_e decode_mode(input logic [1:0] m, input logic mirror_ok);
    return m[1] ? MODE_FILL : (m[0] && mirror_ok) ? MODE_MIRROR : MODE_NORMAL;
  endfunction
endpackage

// File: rtl/fmem_pixel_unpack.sv
// fmem_pixel_unpack: captures a packed memory word and emits one registered pixel per clock
//   i_clk, rst            clock, sync active-high reset
//   i_cap, i_rdata        capture strobe and packed word (pixel 0 in LSBs)
//   i_de, i_phase, i_rev  pixel strobe, pixel slot in word, reverse slot order
//   i_fill_en, i_fill     replace pixel with fill colour
//   o_de, o_data          registered pixel strobe and pixel (0 when not de)
module fmem_pixel_unpack
  import fmem_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int PPW        = 4,
  parameter int MEM_WIDTH  = DATA_WIDTH*PPW,
  parameter int PH_W       = (PPW > 1) ? $clog2(PPW) : 1
)(
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_cap,
  input  logic [MEM_WIDTH-1:0]  i_rdata,
  input  logic                  i_de,
  input  logic [PH_W-1:0]       i_phase,
  input  logic                  i_rev,
  input  logic                  i_fill_en,
  input  logic [DATA_WIDTH-1:0] i_fill,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [MEM_WIDTH-1:0]  r_word;
  logic [PH_W-1:0]       w_sel;
  logic [DATA_WIDTH-1:0] w_pix;
  always_comb begin
    w_sel = i_rev ? PH_W'(PPW-1) - i_phase : i_phase;
    w_pix = r_word[w_sel*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_word <= '0;
      o_de   <= 1'b0;
      o_data <= '0;
    end else begin
      if (i_cap) r_word <= i_rdata;
      o_de   <= i_de;
      o_data <= !i_de ? '0 : i_fill_en ? i_fill : w_pix;
    end
  end
endmodule

// File: rtl/fmem_read_stream_ctrl.sv
// fmem_read_stream_ctrl: regenerates active video from sync/porch timing and streams pixels from frame memory
//   i_clk, rst                 clock, sync active-high reset
//   i_vsync, i_hsync           sync levels, rising edge starts frame/line
//   i_v*/i_h*                  porch, pulse and resolution timing
//   i_base_addr, i_mode        frame base word and mode, sampled at vsync rise
//   i_fill                     fill colour
//   o_ren, o_raddr, i_rdata    frame memory read port
//   o_vsync, o_hsync           syncs delayed by RD_LAT+2
//   o_de, o_data               pixel stream, same delay
//   o_err                      sticky: [0] vsync in active lines, [1] short line
module fmem_read_stream_ctrl
  import fmem_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int PPW        = 4,
  parameter int MEM_WIDTH  = DATA_WIDTH*PPW,
  parameter int ADDR_DEPTH = 512*512/4,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
  parameter int RD_LAT     = 1
)(
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_vsync,
  input  logic                  i_hsync,
  input  logic [PORCH_W-1:0]    i_vfp,
  input  logic [PORCH_W-1:0]    i_vbp,
  input  logic [PULSE_W-1:0]    i_vpulse,
  input  logic [RES_W-1:0]      i_vres,
  input  logic [PORCH_W-1:0]    i_hfp,
  input  logic [PORCH_W-1:0]    i_hbp,
  input  logic [PULSE_W-1:0]    i_hpulse,
  input  logic [RES_W-1:0]      i_hres,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [1:0]            i_mode,
  input  logic [DATA_WIDTH-1:0] i_fill,
  output logic                  o_ren,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [MEM_WIDTH-1:0]  i_rdata,
  output logic                  o_vsync,
  output logic                  o_hsync,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_err
);
  localparam int LAT  = RD_LAT + 2;
  localparam int PH_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int LW   = 13;
  localparam int SW   = ADDR_WIDTH + RES_W;
  logic [LAT-1:0]              r_vsd, r_hsd;
  logic [HCNT_W-1:0]           r_hcnt, w_hcnt;
  logic [VCNT_W-1:0]           r_vcnt, w_vcnt;
  state_e                      r_state, w_state;
  mode_e                       r_mode;
  logic [RES_W-1:0]            r_wpl, w_idx, w_word, w_off;
  logic [ADDR_WIDTH-1:0]       r_line_base, w_raddr;
  logic [SW-1:0]               w_sum;
  logic [LW-1:0]               w_vstart, w_vend, w_hstart, w_hend, w_htot;
  logic [PH_W-1:0]             w_phase;
  logic                        w_vedge, w_hedge, w_de, w_ren, r_had_de, r_hseen;
  logic [1:0]                  r_err;
  logic [RD_LAT:0]             r_pde, r_prev, r_pfill;
  logic [RD_LAT-1:0]           r_pren;
  logic [RD_LAT:0][PH_W-1:0]   r_pph;
  logic                        w_unused;
  // the front porch only shapes the frame externally; VDONE simply waits for the next vsync
  assign w_unused = ^i_vfp;
  // the first two taps of the sync delay lines double as the edge detectors
  assign w_vedge = r_vsd[0] & ~r_vsd[1];
  assign w_hedge = r_hsd[0] & ~r_hsd[1];
  always_comb begin
    w_vstart = LW'(i_vpulse) + LW'(i_vbp);
    w_vend   = w_vstart + LW'(i_vres);
    w_hstart = LW'(i_hpulse) + LW'(i_hbp);
    w_hend   = w_hstart + LW'(i_hres);
    w_htot   = w_hend + LW'(i_hfp);
    w_hcnt   = w_hedge ? '0 : r_hcnt;
    w_vcnt   = w_vedge ? '0 : (w_hedge && r_vcnt != '1) ? r_vcnt + VCNT_W'(1) : r_vcnt;
  end
  always_comb begin
    w_state = r_state;
    if (w_vedge) w_state = ST_VBLANK;
    else if (r_state == ST_VBLANK && LW'(w_vcnt) == w_vstart) w_state = ST_VACTIVE;
    else if (r_state == ST_VACTIVE && LW'(w_vcnt) == w_vend) w_state = ST_VDONE;
  end
  always_comb begin
    w_de    = w_state == ST_VACTIVE && LW'(w_vcnt) >= w_vstart && LW'(w_vcnt) < w_vend &&
              LW'(w_hcnt) >= w_hstart && LW'(w_hcnt) < w_hend;
    w_idx   = RES_W'(LW'(w_hcnt) - w_hstart);
    w_word  = w_idx / RES_W'(PPW);
    w_phase = PH_W'(w_idx % RES_W'(PPW));
    w_off   = r_mode == MODE_MIRROR ? r_wpl - RES_W'(1) - w_word : w_word;
    w_sum   = SW'(r_line_base) + SW'(w_off);
    w_raddr = ADDR_WIDTH'(w_sum % SW'(ADDR_DEPTH));
    w_ren   = w_de && w_phase == '0 && r_mode != MODE_FILL;
  end
  assign o_ren   = w_ren;
  assign o_raddr = w_ren ? w_raddr : '0;
  assign o_vsync = r_vsd[LAT-1];
  assign o_hsync = r_hsd[LAT-1];
  assign o_err   = r_err;
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_vsd       <= '0;
      r_hsd       <= '0;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_state     <= ST_UNLOCKED;
      r_mode      <= MODE_NORMAL;
      r_wpl       <= '0;
      r_line_base <= '0;
      r_had_de    <= 1'b0;
      r_hseen     <= 1'b0;
      r_err       <= '0;
      r_pde       <= '0;
      r_prev      <= '0;
      r_pfill     <= '0;
      r_pren      <= '0;
      r_pph       <= '0;
    end else begin
      r_vsd    <= {r_vsd[LAT-2:0], i_vsync};
      r_hsd    <= {r_hsd[LAT-2:0], i_hsync};
      r_hcnt   <= (w_hcnt == '1) ? w_hcnt : w_hcnt + HCNT_W'(1);
      r_vcnt   <= w_vcnt;
      r_state  <= w_state;
      r_had_de <= (w_vedge || w_hedge) ? w_de : (r_had_de | w_de);
      r_hseen  <= r_hseen | w_hedge;
      r_err[0] <= r_err[0] | (w_vedge && r_state == ST_VACTIVE);
      // the very first line after reset has an unknown start, so it is not measured
      r_err[1] <= r_err[1] | (w_hedge && r_hseen && LW'(r_hcnt) < w_htot);
      if (w_vedge) begin
        r_mode      <= decode_mode(i_mode, (LW'(i_hres) % LW'(PPW)) == '0);
        r_wpl       <= RES_W'((LW'(i_hres) + LW'(PPW-1)) / LW'(PPW));
        r_line_base <= i_base_addr;
      end else if (w_hedge && r_had_de) begin
        // advancing on the line that follows keeps truncated lines from shifting later ones
        r_line_base <= ADDR_WIDTH'((SW'(r_line_base) + SW'(r_wpl)) % SW'(ADDR_DEPTH));
      end
      r_pde   <= {r_pde[RD_LAT-1:0], w_de};
      r_prev  <= {r_prev[RD_LAT-1:0], r_mode == MODE_MIRROR};
      r_pfill <= {r_pfill[RD_LAT-1:0], r_mode == MODE_FILL};
      r_pren  <= RD_LAT'({r_pren, w_ren});
      r_pph   <= {r_pph[RD_LAT-1:0], w_phase};
    end
  end
  fmem_pixel_unpack #(
    .DATA_WIDTH (DATA_WIDTH),
    .PPW        (PPW),
    .MEM_WIDTH  (MEM_WIDTH),
    .PH_W       (PH_W)
  ) u_unpack (
    .i_clk     (i_clk),
    .rst       (rst),
    .i_cap     (r_pren[RD_LAT-1]),
    .i_rdata   (i_rdata),
    .i_de      (r_pde[RD_LAT]),
    .i_phase   (r_pph[RD_LAT]),
    .i_rev     (r_prev[RD_LAT]),
    .i_fill_en (r_pfill[RD_LAT]),
    .i_fill    (i_fill),
    .o_de      (o_de),
    .o_data    (o_data)
  );
endmodule

// File: tb/tb_fmem_read_stream_ctrl.sv
// tb_fmem_read_stream_ctrl: directed checks of the read stream controller at RD_LAT 1 and 3
module tb_fmem_read_stream_ctrl;
  localparam int DW = 24, PPW = 4, MW = 96, AW = 16;
  logic clk = 0, rst = 1, vs = 0, hs = 0;
  logic [9:0] vfp = 1, vbp = 1, hfp = 2, hbp = 2;
  logic [3:0] vpulse = 1, hpulse = 2;
  logic [10:0] vres = 2, hres = 8;
  logic [AW-1:0] base = 0;
  logic [1:0] mode = 0;
  logic [DW-1:0] fill = 0;
  logic ren_a, ren_b, ovs_a, ovs_b, ohs_a, ohs_b, ode_a, ode_b;
  logic [AW-1:0] raddr_a, raddr_b;
  logic [MW-1:0] rdata_a = 0, rdata_b = 0;
  logic [MW-1:0] pb0 = 0, pb1 = 0;
  logic [DW-1:0] odata_a, odata_b;
  logic [1:0] err_a, err_b;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int t_vs = 0, t_vsa = 0, t_vsb = 0, t_dea = -1, t_deb = -1;
  logic vs_q = 0, ovsa_q = 0, ovsb_q = 0;
  logic [AW-1:0] qa_addr[$], qb_addr[$];
  logic [DW-1:0] qa_data[$], qb_data[$];
  always #5 clk = ~clk;
  fmem_read_stream_ctrl #(.RD_LAT(1)) dut_a (
    .i_clk(clk), .rst(rst), .i_vsync(vs), .i_hsync(hs),
    .i_vfp(vfp), .i_vbp(vbp), .i_vpulse(vpulse), .i_vres(vres),
    .i_hfp(hfp), .i_hbp(hbp), .i_hpulse(hpulse), .i_hres(hres),
    .i_base_addr(base), .i_mode(mode), .i_fill(fill),
    .o_ren(ren_a), .o_raddr(raddr_a), .i_rdata(rdata_a),
    .o_vsync(ovs_a), .o_hsync(ohs_a), .o_de(ode_a), .o_data(odata_a), .o_err(err_a));
  fmem_read_stream_ctrl #(.RD_LAT(3)) dut_b (
    .i_clk(clk), .rst(rst), .i_vsync(vs), .i_hsync(hs),
    .i_vfp(vfp), .i_vbp(vbp), .i_vpulse(vpulse), .i_vres(vres),
    .i_hfp(hfp), .i_hbp(hbp), .i_hpulse(hpulse), .i_hres(hres),
    .i_base_addr(base), .i_mode(mode), .i_fill(fill),
    .o_ren(ren_b), .o_raddr(raddr_b), .i_rdata(rdata_b),
    .o_vsync(ovs_b), .o_hsync(ohs_b), .o_de(ode_b), .o_data(odata_b), .o_err(err_b));
  function automatic logic [MW-1:0] mem_word(input logic [AW-1:0] a);
    logic [MW-1:0] w;
    for (int k = 0; k < PPW; k++) w[k*DW +: DW] = DW'(32'(a) * 4 + k);
    return w;
  endfunction
  always @(posedge clk) begin
    rdata_a <= mem_word(raddr_a);
    pb0 <= mem_word(raddr_b);
    pb1 <= pb0;
    rdata_b <= pb1;
  end
  always @(negedge clk) begin
    cyc++;
    if (vs && !vs_q) begin t_vs = cyc; t_dea = -1; t_deb = -1; end
    if (ovs_a && !ovsa_q) t_vsa = cyc;
    if (ovs_b && !ovsb_q) t_vsb = cyc;
    if (ode_a && t_dea < 0) t_dea = cyc;
    if (ode_b && t_deb < 0) t_deb = cyc;
    vs_q = vs; ovsa_q = ovs_a; ovsb_q = ovs_b;
    if (ren_a) qa_addr.push_back(raddr_a);
    if (ren_b) qb_addr.push_back(raddr_b);
    if (ode_a) qa_data.push_back(odata_a);
    if (ode_b) qb_data.push_back(odata_b);
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic line(input int vs_from, input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      hs = (c < 32'(hpulse));
      vs = (c >= vs_from);
    end
  endtask
  task automatic frame();
    line(0, 14);
    repeat (4) line(99, 14);
  endtask
  task automatic clr();
    qa_addr.delete(); qb_addr.delete(); qa_data.delete(); qb_data.delete();
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_ren"}, ren_a, 0);
    check({tag, "_raddr"}, raddr_a, 0);
    check({tag, "_de"}, ode_a, 0);
    check({tag, "_data"}, odata_a, 0);
    check({tag, "_err"}, err_a, 0);
    check({tag, "_vs"}, ovs_a, 0);
    check({tag, "_hs"}, ohs_a, 0);
    check({tag, "_de_b"}, ode_b, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("rst");
    @(posedge clk); #1 rst = 0;
    clr(); frame();
    check("t1_a_nren", qa_addr.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_a_addr", qa_addr[i], i);
    check("t1_a_nde", qa_data.size(), 16);
    for (int i = 0; i < 16; i++) check("t1_a_data", qa_data[i], i);
    check("t1_b_nren", qb_addr.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_b_addr", qb_addr[i], i);
    check("t1_b_nde", qb_data.size(), 16);
    for (int i = 0; i < 16; i++) check("t1_b_data", qb_data[i], i);
    check("t1_a_vs_lat", t_vsa - t_vs, 3);
    check("t1_b_vs_lat", t_vsb - t_vs, 5);
    check("t1_a_de_at", t_dea - t_vs, 36);
    check("t1_b_de_at", t_deb - t_vs, 38);
    mode = 1; clr(); frame();
    check("t2_nren", qa_addr.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_addr", qa_addr[i], i ^ 1);
    check("t2_nde", qa_data.size(), 16);
    for (int i = 0; i < 16; i++) check("t2_data", qa_data[i], (i < 8) ? 7 - i : 23 - i);
    check("t2_b_data0", qb_data[0], 7);
    mode = 2; fill = 24'hFF0000; clr(); frame();
    check("t3_nren", qa_addr.size(), 0);
    check("t3_nde", qa_data.size(), 16);
    for (int i = 0; i < 16; i++) check("t3_data", qa_data[i], 32'hFF0000);
    mode = 0; base = 16'hFFFF; clr(); frame();
    check("t4_nren", qa_addr.size(), 4);
    for (int i = 0; i < 4; i++) check("t4_addr", qa_addr[i], (i == 0) ? 32'hFFFF : i - 1);
    for (int i = 0; i < 8; i++) check("t4_data", qa_data[i], (i < 4) ? 262140 + i : i - 4);
    check("t4_err", err_a, 0);
    base = 0;
    line(0, 14); line(99, 14); line(99, 14); line(6, 14);
    check("t5_err_v", err_a, 2'b01);
    clr();
    repeat (4) line(99, 14);
    check("t5_nren", qa_addr.size(), 4);
    for (int i = 0; i < 4; i++) check("t5_addr", qa_addr[i], i);
    line(99, 11); line(99, 14);
    check("t5_err_h", err_a, 2'b11);
    check("t5_err_h_b", err_b, 2'b11);
    line(0, 14); line(99, 14); line(99, 14); line(99, 6);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_idle("t6_rst");
    clr();
    repeat (3) line(99, 14);
    check("t6_nde_nolock", qa_data.size(), 0);
    check("t6_nren_nolock", qa_addr.size(), 0);
    clr(); frame();
    check("t6_nde", qa_data.size(), 16);
    for (int i = 0; i < 16; i++) check("t6_data", qa_data[i], i);
    check("t6_b_nde", qb_data.size(), 16);
    for (int i = 0; i < 16; i++) check("t6_b_data", qb_data[i], i);
    check("t6_err", err_a, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
